// File: rtl/ws2812_serializer.sv
// ws2812_serializer
// Frame-level WS2812 waveform generator. On Start it walks the GRB bit
// stream through an external 8-bit bit counter. It emits one NRZ high/low
// pulse per bit on LedOut, then holds the line low for the latch interval.
//
// Parameters:
//   NUM_BITS  bits per frame (1..256)
//   T0H       high cycles for a 0 bit
//   T1H       high cycles for a 1 bit
//   TBIT      total cycles per bit (must exceed T0H and T1H)
//   TLATCH    low cycles after the last bit (max 8191)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   Start         frame request, sampled only in IDLE
//   BitData       value of bit Count of the frame (combinational from Count)
//   Count         current bit index from the external bit counter
//   ClearCounter  holds the bit counter at 0 (IDLE and LATCH)
//   IncCounter    advances the bit counter (last cycle of each bit)
//   LedOut        registered serial line to the strip
//   Busy          high from Start acceptance until frame completion
//   Done          one-cycle pulse at frame completion
//
// Optional feature macro: GRB_AUTO_REFRESH_EN
//   When defined, the end of LATCH pulses Done and goes straight back to
//   SEND. Frames then repeat forever with Busy held high, until reset.

module ws2812_serializer #(
   parameter int NUM_BITS = 240,
   parameter int T0H      = 40,
   parameter int T1H      = 80,
   parameter int TBIT     = 125,
   parameter int TLATCH   = 6000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       BitData,
   input  logic [7:0] Count,
   output logic       ClearCounter,
   output logic       IncCounter,
   output logic       LedOut,
   output logic       Busy,
   output logic       Done
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      LATCH
   } stateT;

   localparam logic [12:0] TBIT_LAST   = 13'(TBIT - 1);
   localparam logic [12:0] TLATCH_LAST = 13'(TLATCH - 1);
   localparam logic [12:0] T0H_W       = 13'(T0H);
   localparam logic [12:0] T1H_W       = 13'(T1H);
   // NUM_BITS=256 truncates to 255; the final IncCounter wraps Count to 0,
   // and LATCH clears the counter anyway.
   localparam logic [7:0]  LAST_BIT    = 8'(NUM_BITS - 1);

   stateT       state;
   logic [12:0] timer;
   logic        curBit;
   logic        bitNow;
   logic        highNow;

   // The bit value is captured on the first cycle of each bit. On that cycle
   // the stored copy is stale, so BitData is used directly. Either way the
   // high length stays constant for the whole bit.
   always_comb begin
      bitNow  = (timer == 13'd0) ? BitData : curBit;
      highNow = timer < (bitNow ? T1H_W : T0H_W);
   end

   // Counter controls are decoded straight from state and timer. They can
   // never overlap, because SEND excludes both IDLE and LATCH.
   assign ClearCounter = (state == IDLE) || (state == LATCH);
   assign IncCounter   = (state == SEND) && (timer == TBIT_LAST);

   // Main FSM. One shared timer counts bit phase in SEND and latch time in
   // LATCH. LedOut is registered, so it trails the timer by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         timer  <= 13'd0;
         curBit <= 1'b0;
         LedOut <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               LedOut <= 1'b0;
               Done   <= 1'b0;
               Busy   <= 1'b0;
               timer  <= 13'd0;
               if (Start) begin
                  state <= SEND;
                  Busy  <= 1'b1;
               end
            end

            SEND: begin
               Done   <= 1'b0;
               Busy   <= 1'b1;
               LedOut <= highNow;
               if (timer == 13'd0) begin
                  curBit <= BitData;
               end
               if (timer == TBIT_LAST) begin
                  timer <= 13'd0;
                  if (Count == LAST_BIT) begin
                     state <= LATCH;
                  end
               end else begin
                  timer <= timer + 13'd1;
               end
            end

            LATCH: begin
               LedOut <= 1'b0;
               if (timer == TLATCH_LAST) begin
                  timer <= 13'd0;
                  Done  <= 1'b1;
`ifdef GRB_AUTO_REFRESH_EN
                  state <= SEND;
                  Busy  <= 1'b1;
`else
                  state <= IDLE;
                  Busy  <= 1'b0;
`endif
               end else begin
                  timer <= timer + 13'd1;
                  Done  <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               timer  <= 13'd0;
               LedOut <= 1'b0;
               Busy   <= 1'b0;
               Done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ws2812_serializer.md
# ws2812_serializer

Frame-level WS2812 waveform generator: on Start, walks the GRB bit stream under control of the external 8-bit bit counter, emits one NRZ high/low pulse per bit on LedOut, then holds the line low for the latch interval. Sits directly in front of the LED strip pin and drives the bit counter's ClearCounter/IncCounter inputs. Its only view of frame position is the counter's Count. It samples BitData, which the frame store supplies for the bit at index Count. Default timing assumes the 100 MHz board clock.

## Interface
- NUM_BITS, 240, bits per frame (24 per LED); legal 1..256.
- T0H, 40, high cycles for a 0 bit (0.40 us).
- T1H, 80, high cycles for a 1 bit (0.80 us).
- TBIT, 125, total cycles per bit (1.25 us); requires T0H < TBIT and T1H < TBIT.
- TLATCH, 6000, low cycles after the last bit (60 us); max 8191.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset.
- Start  in  1  frame request; sampled only in IDLE.
- BitData  in  1  value of bit Count of the current frame, valid combinationally from Count.
- Count  in  8  current bit index from the bit counter.
- ClearCounter  out  1  holds the bit counter at 0.
- IncCounter  out  1  advances the bit counter by one.
- LedOut  out  1  registered serial data line to the strip.
- Busy  out  1  high from Start acceptance until the frame completes.
- Done  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, SEND, LATCH. A 13-bit Timer is shared by SEND (0..TBIT-1) and LATCH (0..TLATCH-1).
- IDLE:
  - ClearCounter=1, LedOut=0, Busy=0.
  - If Start=1: go to SEND, Timer=0.
- SEND, Timer==0:
  - CurBit <= BitData.
  - The high length for this bit is T1H if BitData=1, otherwise T0H. The same value is used for the whole bit.
- SEND, every cycle:
  - The next LedOut is 1 while Timer < high length, else 0.
  - Timer increments.
- SEND, Timer==TBIT-1:
  - IncCounter=1 for exactly this cycle.
  - If Count==NUM_BITS-1, go to LATCH with Timer=0.
  - Otherwise Timer=0 and stay in SEND. The next bit's BitData is then valid because Count has just advanced.
- LATCH:
  - ClearCounter=1, LedOut=0.
  - At Timer==TLATCH-1: Done=1 for one cycle, then go to IDLE (or see Configuration).
- Start while Busy=1 is ignored; there is no queuing.
- Count compare is 8-bit. NUM_BITS=256 compares against 255. The final IncCounter wraps Count to 0, which is harmless because LATCH clears it.
- ClearCounter and IncCounter are never high in the same cycle. Both are decoded from state and Timer.
- Reset, at any time including mid-bit and mid-latch:
  - Next state IDLE, Timer=0, CurBit=0.
  - LedOut=0, Busy=0, Done=0, IncCounter=0, ClearCounter=1.

## Timing
- Reset values: LedOut 0, Busy 0, Done 0, IncCounter 0, ClearCounter 1 (IDLE).
- Start is accepted at edge E0. Busy=1 after E0.
- LedOut rises at E1, one cycle of register latency. It stays high T0H or T1H cycles and the bit period is exactly TBIT cycles.
- Consecutive bits are gapless: the rising edge of bit k+1 is exactly TBIT cycles after that of bit k.
- Frame length from E0 to the Done pulse is NUM_BITS*TBIT + TLATCH cycles. Busy drops on the same edge Done pulses.
- The earliest new Start acceptance is the cycle after Done.

## Configuration
- GRB_AUTO_REFRESH_EN defined:
  - At the end of LATCH, the block pulses Done and goes straight to SEND (Timer=0) instead of IDLE.
  - Frames repeat continuously with Busy held at 1. Start is needed only for the first frame.
  - Only reset returns the block to IDLE.
- Not defined: the block returns to IDLE after every frame, as described above.

## Test plan
- Reset mid-bit: with a bit in progress, assert reset for 1 cycle -> LedOut=0, Busy=0, ClearCounter=1 on the next cycle. A subsequent Start restarts at bit 0.
- Single LED, all zeros: NUM_BITS=24, BitData=0, pulse Start -> 24 pulses of 40 high / 85 low cycles. Then 6000 low cycles, Done pulse at E0+24*125+6000=9000, Busy low.
- Alternating data: BitData = Count[0] -> high widths alternate 40, 80, 40, ... Rising edges are exactly 125 cycles apart, and exactly one IncCounter pulse occurs per bit, 24 in total.
- Start ignored while busy: hold Start=1 throughout a frame -> only one frame until Done. The next frame begins the cycle after Done, since Start is still high.
- Boundary NUM_BITS=256 with a real bit counter: all ones -> 256 pulses of 80 high cycles. Count wraps to 0 and LATCH follows, with no extra pulse.
- Auto refresh: GRB_AUTO_REFRESH_EN defined, NUM_BITS=2, TLATCH=10 -> Done pulses every 2*125+10=260 cycles, Busy stays 1, and the LedOut pattern repeats.
